// File: rtl/clkdiv_sched.sv
// clkdiv_sched: arbitrates NREQ requesters onto one shared clock divider and only ever
// hands it over between whole periods. Define CLKDIV_SCHED_PRIO_EN to give requester 0 fixed priority.
module clkdiv_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int PER_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_div,
    input  logic [NREQ*PER_W-1:0] req_per,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      div_out,
    output logic                  div_valid,
    output logic                  period_end,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    // Handshake: a requester holds req high until it sees its done pulse; gnt is
    // one-hot while the divider is owned, and done/err are single-cycle pulses.

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ARB, RUN, RELEASE} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WIDTH-1:0]  div_l_q;
    logic [PER_W-1:0]  rem_q;
    logic [WIDTH-1:0]  cnt_q;
    logic              drop_q;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  div_out_q;
    logic              div_valid_q;
    logic [NREQ-1:0]   done_q;
    logic              err_q;
    logic              busy_q;

    logic [WIDTH-1:0]  div_arr [NREQ];
    logic [PER_W-1:0]  per_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign div_arr[g] = req_div[g*WIDTH +: WIDTH];
        assign per_arr[g] = req_per[g*PER_W +: PER_W];
    end

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [WIDTH-1:0]  pick_div;
    logic [PER_W-1:0]  pick_per;

    // Rotating search starting one past the last served (or rejected) requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = last_q;
`ifdef CLKDIV_SCHED_PRIO_EN
        if (req[0]) begin
            pick_found = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + IDX_W'(1);
`ifdef CLKDIV_SCHED_PRIO_EN
            if (!pick_found && cand != '0 && req[cand]) begin
`else
            if (!pick_found && req[cand]) begin
`endif
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_div = div_arr[pick_idx];
    assign pick_per = per_arr[pick_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            idx_q       <= '0;
            div_l_q     <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            gnt_q       <= '0;
            div_out_q   <= '0;
            div_valid_q <= 1'b0;
            done_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (|req) begin
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ARB: begin
                    cnt_q  <= '0;
                    drop_q <= 1'b0;
                    if (!pick_found) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (pick_div < WIDTH'(2)) begin
                        err_q   <= 1'b1;
                        last_q  <= pick_idx;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q       <= pick_idx;
                        div_l_q     <= pick_div;
                        rem_q       <= (pick_per == '0) ? PER_W'(1) : pick_per;
                        gnt_q       <= NREQ'(1) << pick_idx;
                        div_out_q   <= pick_div;
                        div_valid_q <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    // A dropped request is remembered so the current period still completes.
                    if (!req[idx_q]) begin
                        drop_q <= 1'b1;
                    end
                    if (period_end) begin
                        cnt_q <= '0;
                        if (rem_q == PER_W'(1) || drop_q || !req[idx_q]) begin
                            state_q     <= RELEASE;
                            gnt_q       <= '0;
                            div_out_q   <= '0;
                            div_valid_q <= 1'b0;
                            done_q      <= NREQ'(1) << idx_q;
                        end else begin
                            rem_q <= rem_q - PER_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                RELEASE: begin
                    last_q  <= idx_q;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign period_end = (state_q == RUN) && (cnt_q == div_l_q - WIDTH'(1));
    assign gnt        = gnt_q;
    assign div_out    = div_out_q;
    assign div_valid  = div_valid_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched (NREQ=4, WIDTH=8, PER_W=4); also meaningful with CLKDIV_SCHED_PRIO_EN.
module tb_clkdiv_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_div = '0;
    logic [15:0] req_per = '0;
    logic [3:0]  gnt;
    logic [7:0]  div_out;
    logic        div_valid;
    logic        period_end;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Packed view of every functional output: {gnt, div_out, div_valid, period_end, done, err, busy}
    logic [19:0] obs;
    assign obs = {gnt, div_out, div_valid, period_end, done, err, busy};

`ifdef CLKDIV_SCHED_PRIO_EN
    localparam logic [3:0] RR_ODD   = 4'b0001;
    localparam logic [3:0] REJ_NEXT = 4'b0001;
    localparam logic [3:0] SECOND   = 4'b0001;
`else
    localparam logic [3:0] RR_ODD   = 4'b0100;
    localparam logic [3:0] REJ_NEXT = 4'b0100;
    localparam logic [3:0] SECOND   = 4'b0010;
`endif

    clkdiv_sched #(.WIDTH(8), .NREQ(4), .PER_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_div    (req_div),
        .req_per    (req_per),
        .gnt        (gnt),
        .div_out    (div_out),
        .div_valid  (div_valid),
        .period_end (period_end),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic on, input logic [7:0] d, input logic [3:0] p);
        req[i]             = on;
        req_div[i*8 +: 8]  = d;
        req_per[i*4 +: 4]  = p;
    endtask

    task automatic apply_reset();
        req     = '0;
        req_div = '0;
        req_per = '0;
        rst     = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 20'h0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_immediate: got %h/%0d expected 00000/0", obs, dbg_state);
        end
        for (int c = 1; c <= 2; c++) begin
            step();
            n_checks++;
            if (obs !== 20'h0 || dbg_state !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_hold c=%0d: got %h/%0d expected 00000/0", c, obs, dbg_state);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        logic [19:0] exp;
        logic        run;
        int          dv_cnt = 0;
        apply_reset();
        set_req(0, 1'b1, 8'd4, 4'd2);
        for (int c = 1; c <= 12; c++) begin
            step();
            run = (c >= 2 && c <= 9);
            exp = {run ? 4'b0001 : 4'b0000, run ? 8'd4 : 8'd0, run, (c == 5 || c == 9),
                   (c == 10) ? 4'b0001 : 4'b0000, 1'b0, (c <= 10)};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL single_grant c=%0d: got %h expected %h", c, obs, exp);
            end
            if (div_valid) dv_cnt++;
            if (c == 10) req[0] = 1'b0;
        end
        n_checks++;
        if (dv_cnt != 8) begin
            n_errors++;
            $display("FAIL single_grant_len: got %0d expected 8", dv_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [19:0] exp;
        logic [3:0]  who;
        logic        run;
        logic        rel;
        int          ph;
        int          g;
        apply_reset();
        set_req(0, 1'b1, 8'd3, 4'd1);
        set_req(2, 1'b1, 8'd3, 4'd1);
        for (int c = 1; c <= 24; c++) begin
            step();
            ph = 5;
            g  = 0;
            if (c >= 2) begin
                ph = (c - 2) % 6;
                g  = (c - 2) / 6;
            end
            who = (g % 2 == 0) ? 4'b0001 : RR_ODD;
            run = (ph < 3);
            rel = (ph == 3);
            exp = {run ? who : 4'b0000, run ? 8'd3 : 8'd0, run, run && ph == 2,
                   rel ? who : 4'b0000, 1'b0, ph != 4};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL round_robin c=%0d: got %h expected %h", c, obs, exp);
            end
            if (c == 23) req = '0;
        end
    endtask

    task automatic test_reject();
        logic [19:0] exp;
        int          err_cnt = 0;
        apply_reset();
        set_req(1, 1'b1, 8'd1, 4'd3);
        for (int c = 1; c <= 9; c++) begin
            step();
            case (c)
                1, 3, 5: exp = {4'b0000, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
                2, 4:    exp = {4'b0000, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
                6, 7, 8: exp = {REJ_NEXT, 8'd3, 1'b1, c == 8, 4'b0000, 1'b0, 1'b1};
                default: exp = {4'b0000, 8'd0, 1'b0, 1'b0, REJ_NEXT, 1'b0, 1'b1};
            endcase
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL reject c=%0d: got %h expected %h", c, obs, exp);
            end
            if (err) err_cnt++;
            if (c == 4) begin
                set_req(1, 1'b0, 8'd1, 4'd3);
                set_req(0, 1'b1, 8'd3, 4'd1);
                set_req(2, 1'b1, 8'd3, 4'd0);
            end
            if (c == 9) req = '0;
        end
        n_checks++;
        if (err_cnt != 2) begin
            n_errors++;
            $display("FAIL reject_err_count: got %0d expected 2", err_cnt);
        end
    endtask

    task automatic test_early_drop();
        logic [19:0] exp;
        logic        run;
        apply_reset();
        set_req(3, 1'b1, 8'd5, 4'd8);
        for (int c = 1; c <= 13; c++) begin
            step();
            run = (c >= 2 && c <= 11);
            exp = {run ? 4'b1000 : 4'b0000, run ? 8'd5 : 8'd0, run, (c == 6 || c == 11),
                   (c == 12) ? 4'b1000 : 4'b0000, 1'b0, (c <= 12)};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL early_drop c=%0d: got %h expected %h", c, obs, exp);
            end
            if (c == 8) req[3] = 1'b0;
        end
    endtask

    task automatic test_priority();
        logic [19:0] exp;
        apply_reset();
        set_req(0, 1'b1, 8'd2, 4'd1);
        set_req(1, 1'b1, 8'd2, 4'd1);
        for (int c = 1; c <= 13; c++) begin
            step();
            case (c)
                1, 6, 11: exp = {4'b0000, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
                2, 3:     exp = {4'b0001, 8'd2, 1'b1, c == 3, 4'b0000, 1'b0, 1'b1};
                4:        exp = {4'b0000, 8'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1};
                5, 10:    exp = 20'h0;
                7, 8:     exp = {SECOND, 8'd2, 1'b1, c == 8, 4'b0000, 1'b0, 1'b1};
                9:        exp = {4'b0000, 8'd0, 1'b0, 1'b0, SECOND, 1'b0, 1'b1};
                default:  exp = {4'b0010, 8'd2, 1'b1, c == 13, 4'b0000, 1'b0, 1'b1};
            endcase
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL priority c=%0d: got %h expected %h", c, obs, exp);
            end
            if (c == 9) req[0] = 1'b0;
        end
        req = '0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_req(0, 1'b1, 8'd4, 4'd3);
        for (int c = 1; c <= 4; c++) step();
        n_checks++;
        if (gnt !== 4'b0001 || div_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset_pre: got gnt=%b dv=%b expected 0001/1", gnt, div_valid);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 20'h0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL async_reset_now: got %h/%0d expected 00000/0", obs, dbg_state);
        end
        req = '0;
        step();
        n_checks++;
        if (obs !== 20'h0) begin
            n_errors++;
            $display("FAIL async_reset_hold: got %h expected 00000", obs);
        end
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if (obs !== 20'h0) begin
                n_errors++;
                $display("FAIL async_reset_after c=%0d: got %h expected 00000", c, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_reject();
        test_early_drop();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
